// File: rtl/rr_ring_arbiter.sv
// rr_ring_arbiter: round-robin arbiter with a one-hot rotating priority ring,
// grant hold limit and forced-release timeout pulse.  Rev 1.0
`default_nettype none

module rr_ring_arbiter #(
   parameter int N        = 4,
   parameter int HOLD_MAX = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         req,
   input  logic                 done,
   output logic [N-1:0]         grant,
   output logic [$clog2(N)-1:0] grant_id,
   output logic                 busy,
   output logic                 timeout
);

   localparam int IDW = $clog2(N);
   localparam int HW  = $clog2(HOLD_MAX + 1);
   localparam logic [N-1:0]  ONE       = N'(1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MAX - 1);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t         state;
   logic [N-1:0]   ptr;
   logic [HW-1:0]  hold;

   logic [IDW-1:0] ptr_idx;
   logic [IDW-1:0] sel_idx;
   logic [IDW-1:0] cand;
   logic           sel_found;
   int             pos;

   logic           owner_req;
   logic           at_limit;
   logic           release_now;

   // Circular search for the first requester starting at the ring pointer.
   always_comb begin
      ptr_idx   = '0;
      sel_idx   = '0;
      sel_found = 1'b0;
      cand      = '0;
      pos       = 0;
      for (int i = 0; i < N; i++) begin
         if (ptr[i]) ptr_idx = IDW'(i);
      end
      for (int k = 0; k < N; k++) begin
         pos = int'(ptr_idx) + k;
         if (pos >= N) pos = pos - N;
         cand = IDW'(pos);
         if (!sel_found && req[cand]) begin
            sel_found = 1'b1;
            sel_idx   = cand;
         end
      end
   end

   assign owner_req   = req[grant_id];
   assign at_limit    = (hold == HOLD_LAST);
   assign release_now = done || !owner_req || at_limit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         ptr      <= ONE;
         hold     <= '0;
         grant    <= '0;
         grant_id <= '0;
         busy     <= 1'b0;
         timeout  <= 1'b0;
      end else begin
         timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (sel_found) begin
                  grant    <= ONE << sel_idx;
                  grant_id <= sel_idx;
                  busy     <= 1'b1;
                  hold     <= '0;
                  state    <= GRANT;
               end
            end
            GRANT: begin
               if (release_now) begin
                  grant    <= '0;
                  grant_id <= '0;
                  busy     <= 1'b0;
                  ptr      <= {grant[N-2:0], grant[N-1]};
                  // A limit release only counts as forced when nothing else ended it.
                  timeout  <= at_limit && !done && owner_req;
                  state    <= IDLE;
               end else begin
                  hold <= hold + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_rr_ring_arbiter.sv
// tb_rr_ring_arbiter: directed self-checking bench for rr_ring_arbiter (N=4, HOLD_MAX=8).
// Rev 1.0
`default_nettype none

module tb_rr_ring_arbiter;

   localparam int N        = 4;
   localparam int HOLD_MAX = 8;

   logic         clk;
   logic         rst;
   logic [N-1:0] req;
   logic         done;
   logic [N-1:0] grant;
   logic [1:0]   grant_id;
   logic         busy;
   logic         timeout;

   int n_total;
   int n_pass;

   rr_ring_arbiter #(.N(N), .HOLD_MAX(HOLD_MAX)) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .done     (done),
      .grant    (grant),
      .grant_id (grant_id),
      .busy     (busy),
      .timeout  (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp)
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      else
         n_pass++;
   endtask

   task automatic expect_out(input string tag, input logic [3:0] g, input logic [1:0] id,
                             input logic b, input logic t);
      check({tag, ".grant"},    32'(grant),    32'(g));
      check({tag, ".grant_id"}, 32'(grant_id), 32'(id));
      check({tag, ".busy"},     32'(busy),     32'(b));
      check({tag, ".timeout"},  32'(timeout),  32'(t));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [3:0] rot_seq [9];
      logic [1:0] rot_id  [9];
      rot_seq = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                  4'b0000, 4'b1000, 4'b0000, 4'b0001};
      rot_id  = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd3, 2'd0, 2'd0};
      n_total = 0;
      n_pass  = 0;
      rst  = 1'b1;
      req  = '0;
      done = 1'b0;

      // Reset, then a single requester 2
      step();
      step();
      expect_out("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
      req = 4'b0100;
      step();
      expect_out("in_reset_req", 4'b0000, 2'd0, 1'b0, 1'b0);
      rst = 1'b0;
      step();
      expect_out("first_grant", 4'b0100, 2'd2, 1'b1, 1'b0);
      step();
      expect_out("grant_held", 4'b0100, 2'd2, 1'b1, 1'b0);

      // Asynchronous reset mid-grant
      rst = 1'b1;
      #2;
      expect_out("async_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
      req  = 4'b1111;
      done = 1'b1;
      #2;
      rst = 1'b0;

      // Fair rotation with done pulsed every grant cycle
      for (int i = 0; i < 9; i++) begin
         step();
         expect_out($sformatf("rot%0d", i), rot_seq[i], rot_id[i], rot_seq[i] != 4'b0000, 1'b0);
      end

      // Wrap priority: owner 0 released with req=1001, then owner 3
      req = 4'b1001;
      step();
      expect_out("wrap_rel0", 4'b0000, 2'd0, 1'b0, 1'b0);
      step();
      expect_out("wrap_g3", 4'b1000, 2'd3, 1'b1, 1'b0);
      step();
      expect_out("wrap_rel3", 4'b0000, 2'd0, 1'b0, 1'b0);
      step();
      expect_out("wrap_g0", 4'b0001, 2'd0, 1'b1, 1'b0);

      // Hold limit: requester 1 alone, no done
      done = 1'b0;
      req  = 4'b0010;
      step();
      expect_out("withdraw0", 4'b0000, 2'd0, 1'b0, 1'b0);
      step();
      expect_out("lim_g1", 4'b0010, 2'd1, 1'b1, 1'b0);
      for (int i = 0; i < HOLD_MAX - 1; i++) begin
         step();
         expect_out($sformatf("lim_hold%0d", i), 4'b0010, 2'd1, 1'b1, 1'b0);
      end
      step();
      expect_out("lim_timeout", 4'b0000, 2'd0, 1'b0, 1'b1);
      step();
      expect_out("lim_regrant", 4'b0010, 2'd1, 1'b1, 1'b0);

      // Owner 2 withdraws after 3 cycles; pending 0011 resumes at bit 0
      req  = 4'b0100;
      done = 1'b1;
      step();
      expect_out("to_own2_rel", 4'b0000, 2'd0, 1'b0, 1'b0);
      done = 1'b0;
      step();
      expect_out("own2_g", 4'b0100, 2'd2, 1'b1, 1'b0);
      step();
      step();
      expect_out("own2_c3", 4'b0100, 2'd2, 1'b1, 1'b0);
      req = 4'b0011;
      step();
      expect_out("own2_drop", 4'b0000, 2'd0, 1'b0, 1'b0);
      step();
      expect_out("after_drop", 4'b0001, 2'd0, 1'b1, 1'b0);

      // done coinciding with the hold limit is a normal release
      for (int i = 0; i < HOLD_MAX - 1; i++) begin
         step();
         expect_out($sformatf("co_hold%0d", i), 4'b0001, 2'd0, 1'b1, 1'b0);
      end
      done = 1'b1;
      step();
      expect_out("co_release", 4'b0000, 2'd0, 1'b0, 1'b0);
      done = 1'b0;
      req  = 4'b0000;
      step();
      expect_out("idle_end", 4'b0000, 2'd0, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
